gsu_cache_ctrl: RTL and testbench

- Controller for the GSU 512-byte instruction cache RAM (dual-port, 32 lines x 16 bytes).
- Decides hit/miss of GSU opcode fetches against the cache base register (CBR) and fills missing lines from ROM/RAM through the memory arbiter.
- Arbitrates cache write port A between line fills and SNES host writes ($3100-$32FF window).
- Tracks per-line valid bits.

---
 rtl/gsu_cache_if.sv | 45 ++++
 rtl/gsu_cache_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_gsu_cache_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gsu_cache_if.sv
// GSU cache controller bus bundle: core fetch, memory arbiter,
// host window writes and the dual-port cache RAM ports.
interface gsu_cache_if #(
  parameter int MEM_AW = 24
);
  logic              fetch_req;
  logic [7:0]        fetch_pbr;
  logic [15:0]       fetch_pc;
  logic              fetch_ack;
  logic [7:0]        fetch_data;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic              host_we;
  logic [8:0]        host_addr;
  logic [7:0]        host_data;
  logic [8:0]        cache_addra;
  logic [7:0]        cache_dina;
  logic              cache_wea;
  logic [8:0]        cache_addrb;
  logic [7:0]        cache_doutb;

  modport slave (
    input  fetch_req, fetch_pbr, fetch_pc,
    input  mem_ack, mem_data,
    input  host_we, host_addr, host_data,
    input  cache_doutb,
    output fetch_ack, fetch_data,
    output mem_req, mem_addr,
    output cache_addra, cache_dina, cache_wea,
    output cache_addrb
  );

  modport master (
    output fetch_req, fetch_pbr, fetch_pc,
    output mem_ack, mem_data,
    output host_we, host_addr, host_data,
    output cache_doutb,
    input  fetch_ack, fetch_data,
    input  mem_req, mem_addr,
    input  cache_addra, cache_dina, cache_wea,
    input  cache_addrb
  );
endinterface

// File: rtl/gsu_cache_ctrl.sv
// GSU instruction cache controller: hit/miss, line fill, host port A.
// Define GSU_CACHE_STATS_EN to build the hit/miss counters.
module gsu_cache_ctrl #(
  parameter int LINES     = 32,
  parameter int LINE_LOG2 = 4,
  parameter int MEM_AW    = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cbr_in,
  input  logic        cbr_we,
  input  logic        flush,
  gsu_cache_if.slave  bus,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int LW  = $clog2(LINES);
  localparam int CAW = LW + LINE_LOG2;
  localparam int BW  = 16 - LINE_LOG2;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, HIT_WAIT, FILL, BYPASS
  } state_t;

  state_t               state, state_n;
  logic [BW-1:0]        cbr_q;
  logic [LINES-1:0]     valid;
  logic [CAW-1:0]       addrb_q;
  logic [LW-1:0]        fill_line;
  logic [BW-1:0]        fill_base;
  logic [LINE_LOG2-1:0] byte_idx;
  logic                 pend_v;
  logic [7:0]           pend_d;
  logic                 abort_q;
  logic                 hw_q;

  logic          inv;
  logic [15:0]   off;
  logic          in_win;
  logic [LW-1:0] line;
  logic          fill_wr;
  logic          fill_last;
  logic          host_set;
  logic          unused_ok;

  assign unused_ok = ^cbr_in[LINE_LOG2-1:0];
  assign inv    = cbr_we | flush;
  assign off    = bus.fetch_pc
                - {cbr_q, {LINE_LOG2{1'b0}}};
  assign in_win = (off[15:CAW] == '0);
  assign line   = off[CAW-1:LINE_LOG2];

  // Host owns port A; a pending fill byte waits.
  assign fill_wr   = pend_v & ~bus.host_we & ~inv;
  assign fill_last = fill_wr & (byte_idx == '1);
  assign host_set  = bus.host_we & ~inv
    & (bus.host_addr[LINE_LOG2-1:0] == '1);

  assign bus.cache_addrb = addrb_q;

  always_comb begin
    bus.cache_addra = '0;
    bus.cache_dina  = '0;
    bus.cache_wea   = 1'b0;
    unique case (1'b1)
      bus.host_we: begin
        bus.cache_addra = bus.host_addr;
        bus.cache_dina  = bus.host_data;
        bus.cache_wea   = 1'b1;
      end
      fill_wr: begin
        bus.cache_addra = {fill_line, byte_idx};
        bus.cache_dina  = pend_d;
        bus.cache_wea   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n        = state;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = '0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    unique case (state)
      IDLE:
        if (bus.fetch_req) state_n = LOOKUP;
      LOOKUP:
        if (!in_win)          state_n = BYPASS;
        else if (valid[line]) state_n = HIT_WAIT;
        else                  state_n = FILL;
      HIT_WAIT:
        if (hw_q) begin
          bus.fetch_ack  = 1'b1;
          bus.fetch_data = bus.cache_doutb;
          state_n        = IDLE;
        end
      FILL: begin
        bus.mem_req  = ~pend_v;
        bus.mem_addr = MEM_AW'({bus.fetch_pbr,
                                fill_base, byte_idx});
        if (pend_v) begin
          if (inv || fill_last) state_n = LOOKUP;
        end else if (bus.mem_ack && (inv || abort_q)) begin
          state_n = LOOKUP;
        end
      end
      BYPASS: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = MEM_AW'({bus.fetch_pbr, bus.fetch_pc});
        if (bus.mem_ack) begin
          bus.fetch_ack  = 1'b1;
          bus.fetch_data = bus.mem_data;
          state_n        = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cbr_q     <= '0;
      valid     <= '0;
      addrb_q   <= '0;
      fill_line <= '0;
      fill_base <= '0;
      byte_idx  <= '0;
      pend_v    <= 1'b0;
      pend_d    <= '0;
      abort_q   <= 1'b0;
      hw_q      <= 1'b0;
    end else begin
      if (cbr_we) cbr_q <= cbr_in[15:LINE_LOG2];
      if (inv) begin
        valid <= '0;
      end else begin
        if (fill_last) valid[fill_line] <= 1'b1;
        if (host_set)
          valid[bus.host_addr[CAW-1:LINE_LOG2]] <= 1'b1;
      end
      hw_q <= (state == HIT_WAIT) & ~hw_q;
      if (state == LOOKUP) begin
        addrb_q   <= off[CAW-1:0];
        fill_line <= line;
        fill_base <= cbr_q + BW'(line);
        byte_idx  <= '0;
        abort_q   <= 1'b0;
      end
      if (state == FILL) begin
        if (pend_v) begin
          if (inv) begin
            pend_v <= 1'b0;
          end else if (!bus.host_we) begin
            pend_v   <= 1'b0;
            byte_idx <= byte_idx + 1'b1;
          end
        end else if (bus.mem_ack) begin
          if (!(inv || abort_q)) begin
            pend_v <= 1'b1;
            pend_d <= bus.mem_data;
          end
        end else if (inv) begin
          abort_q <= 1'b1;
        end
      end
    end
  end

`ifdef GSU_CACHE_STATS_EN
  logic hit_ev;
  logic miss_ev;
  assign hit_ev  = (state == HIT_WAIT) & hw_q;
  assign miss_ev = (state == LOOKUP)
                 & ~(in_win & valid[line]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (inv) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_ev && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (miss_ev && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_gsu_cache_ctrl.sv
// Directed self-checking bench for gsu_cache_ctrl.
`timescale 1ns/1ps
module tb_gsu_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cbr_in;
  logic        cbr_we;
  logic        flush;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  gsu_cache_if bus();

  gsu_cache_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cbr_in   (cbr_in),
    .cbr_we   (cbr_we),
    .flush    (flush),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  logic [7:0] ram [0:511];
  initial for (int i = 0; i < 512; i++) ram[i] = 8'h00;
  always @(posedge clk) begin
    if (bus.cache_wea) ram[bus.cache_addra] <= bus.cache_dina;
    bus.cache_doutb <= ram[bus.cache_addrb];
  end

  logic [23:0] mem_log[$];
  int wait_cnt = 0;
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (bus.mem_req) begin
        if (wait_cnt == 2) begin
          bus.mem_ack  = 1'b1;
          bus.mem_data = mem_byte(bus.mem_addr);
          mem_log.push_back(bus.mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  logic [16:0] wr_log[$];
  int req_cycles = 0;
  always @(negedge clk) begin
    if (bus.cache_wea)
      wr_log.push_back({bus.cache_addra, bus.cache_dina});
    if (bus.mem_req) req_cycles++;
  end

  task automatic cbr_load(input logic [15:0] v);
    @(posedge clk); #1;
    cbr_in = v; cbr_we = 1'b1;
    @(posedge clk); #1;
    cbr_we = 1'b0;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.host_we = 1'b1; bus.host_addr = a; bus.host_data = d;
    @(posedge clk); #1;
    bus.host_we = 1'b0;
  endtask

  task automatic do_fetch(input logic [7:0] pbr, input logic [15:0] pc,
                          output logic [7:0] data, output int lat,
                          output logic ack_mem);
    logic got;
    @(posedge clk); #1;
    bus.fetch_pbr = pbr; bus.fetch_pc = pc; bus.fetch_req = 1'b1;
    @(posedge clk);
    lat = 0; data = 8'h00; ack_mem = 1'b0; got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk); lat++;
      if (bus.fetch_ack) begin
        got = 1'b1; data = bus.fetch_data; ack_mem = bus.mem_ack;
      end
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL fetch_timeout pc=%h got no ack want ack in 400", pc);
    end
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
  endtask

  task automatic wait_mem(input int n);
    int g = 0;
    while (mem_log.size() < n && g < 400) begin
      @(negedge clk); g++;
    end
    n_cmp++;
    if (mem_log.size() < n) begin
      n_fail++;
      $display("FAIL wait_mem got %0d want %0d", mem_log.size(), n);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({bus.fetch_ack, bus.mem_req, bus.cache_wea} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctl got %b want 000",
               {bus.fetch_ack, bus.mem_req, bus.cache_wea});
    end
    n_cmp++;
    if ({bus.cache_addrb, bus.cache_addra, bus.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr got %h/%h/%h want 0",
               bus.cache_addrb, bus.cache_addra, bus.mem_addr);
    end
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h/%h want 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_fill;
    int m0, w0, r0, lat;
    logic [7:0] d;
    logic am;
    logic [23:0] ma;
    logic [16:0] wv;
    cbr_load(16'h8000);
    m0 = mem_log.size(); w0 = wr_log.size();
    do_fetch(8'h01, 16'h8005, d, lat, am);
    n_cmp++;
    if (mem_log.size() - m0 !== 16) begin
      n_fail++;
      $display("FAIL fill_reads got %0d want 16", mem_log.size() - m0);
    end
    for (int i = 0; i < 16; i++) begin
      ma = (m0 + i < mem_log.size()) ? mem_log[m0+i] : 24'hxxxxxx;
      n_cmp++;
      if (ma !== 24'h018000 + 24'(i)) begin
        n_fail++;
        $display("FAIL fill_addr[%0d] got %h want %h", i, ma,
                 24'h018000 + 24'(i));
      end
      wv = (w0 + i < wr_log.size()) ? wr_log[w0+i] : 17'hx;
      n_cmp++;
      if (wv !== {9'(i), mem_byte(24'h018000 + 24'(i))}) begin
        n_fail++;
        $display("FAIL fill_write[%0d] got %h want %h", i, wv,
                 {9'(i), mem_byte(24'h018000 + 24'(i))});
      end
    end
    n_cmp++;
    if (d !== mem_byte(24'h018005)) begin
      n_fail++;
      $display("FAIL fill_data got %h want %h", d, mem_byte(24'h018005));
    end
    r0 = req_cycles;
    do_fetch(8'h01, 16'h8005, d, lat, am);
    n_cmp++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL hit_latency got %0d want 3", lat);
    end
    n_cmp++;
    if (req_cycles - r0 !== 0) begin
      n_fail++;
      $display("FAIL hit_no_req got %0d want 0", req_cycles - r0);
    end
    n_cmp++;
    if (d !== mem_byte(24'h018005)) begin
      n_fail++;
      $display("FAIL hit_data got %h want %h", d, mem_byte(24'h018005));
    end
  endtask

  task automatic test_bypass;
    int m0, w0, lat;
    logic [7:0] d;
    logic am;
    m0 = mem_log.size(); w0 = wr_log.size();
    do_fetch(8'h01, 16'h7FFF, d, lat, am);
    n_cmp++;
    if (mem_log.size() - m0 !== 1 || mem_log[m0] !== 24'h017FFF) begin
      n_fail++;
      $display("FAIL bypass_read got n=%0d want one read at 017fff",
               mem_log.size() - m0);
    end
    n_cmp++;
    if (am !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_ack_cycle got %b want 1", am);
    end
    n_cmp++;
    if (d !== mem_byte(24'h017FFF)) begin
      n_fail++;
      $display("FAIL bypass_data got %h want %h", d, mem_byte(24'h017FFF));
    end
    n_cmp++;
    if (wr_log.size() - w0 !== 0) begin
      n_fail++;
      $display("FAIL bypass_no_wea got %0d want 0", wr_log.size() - w0);
    end
  endtask

  task automatic test_host_hit;
    int r0, lat;
    logic [7:0] d;
    logic am;
    cbr_load(16'h0000);
    for (int i = 0; i < 16; i++)
      host_write(9'h020 + 9'(i), 8'hA0 + 8'(i));
    r0 = req_cycles;
    do_fetch(8'h00, 16'h0023, d, lat, am);
    n_cmp++;
    if (d !== 8'hA3 || lat !== 3) begin
      n_fail++;
      $display("FAIL host_hit got %h lat %0d want a3 lat 3", d, lat);
    end
    n_cmp++;
    if (req_cycles - r0 !== 0) begin
      n_fail++;
      $display("FAIL host_hit_no_req got %0d want 0", req_cycles - r0);
    end
  endtask

  task automatic test_flush_mid_fill;
    int m0, w0, lat;
    logic [7:0] d;
    logic am;
    m0 = mem_log.size(); w0 = wr_log.size();
    fork
      do_fetch(8'h02, 16'h0045, d, lat, am);
      begin
        wait_mem(m0 + 8);
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
      end
    join
    n_cmp++;
    if (mem_log.size() - m0 !== 24 || mem_log[m0+8] !== 24'h020040) begin
      n_fail++;
      $display("FAIL flush_restart got n=%0d want 24 restart at 020040",
               mem_log.size() - m0);
    end
    n_cmp++;
    if (wr_log.size() - w0 !== 23 || wr_log[w0+7][16:8] !== 9'h040) begin
      n_fail++;
      $display("FAIL flush_discard got n=%0d want 23 writes",
               wr_log.size() - w0);
    end
    n_cmp++;
    if (d !== mem_byte(24'h020045)) begin
      n_fail++;
      $display("FAIL flush_data got %h want %h", d, mem_byte(24'h020045));
    end
  endtask

  task automatic test_host_during_fill;
    int m0, w0, lat, bad;
    logic [7:0] d;
    logic am;
    m0 = mem_log.size(); w0 = wr_log.size();
    fork
      do_fetch(8'h03, 16'h0065, d, lat, am);
      begin
        wait_mem(m0 + 1);
        @(posedge clk); #1;
        bus.host_we = 1'b1; bus.host_addr = 9'h1F0; bus.host_data = 8'hC3;
        @(posedge clk); #1;
        bus.host_we = 1'b0;
      end
    join
    n_cmp++;
    if (wr_log.size() - w0 !== 17 || wr_log[w0] !== {9'h1F0, 8'hC3}) begin
      n_fail++;
      $display("FAIL host_first got n=%0d want 17 host first",
               wr_log.size() - w0);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (w0 + 1 + i >= wr_log.size() || wr_log[w0+1+i] !==
          {9'h060 + 9'(i), mem_byte(24'h030060 + 24'(i))}) bad++;
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL fill_kept got %0d bad writes want 0", bad);
    end
    n_cmp++;
    if (d !== mem_byte(24'h030065)) begin
      n_fail++;
      $display("FAIL hdf_data got %h want %h", d, mem_byte(24'h030065));
    end
  endtask

  task automatic test_inv_priority;
    int m0, lat;
    logic [7:0] d;
    logic am;
    for (int i = 0; i < 15; i++)
      host_write(9'h020 + 9'(i), 8'h50 + 8'(i));
    @(posedge clk); #1;
    bus.host_we = 1'b1; bus.host_addr = 9'h02F; bus.host_data = 8'h5F;
    flush = 1'b1;
    @(posedge clk); #1;
    bus.host_we = 1'b0; flush = 1'b0;
    m0 = mem_log.size();
    do_fetch(8'h00, 16'h0023, d, lat, am);
    n_cmp++;
    if (mem_log.size() - m0 !== 16) begin
      n_fail++;
      $display("FAIL inv_wins got %0d reads want 16", mem_log.size() - m0);
    end
  endtask

  task automatic test_stats;
    int lat, eh, em;
    logic [7:0] d;
    logic am;
`ifdef GSU_CACHE_STATS_EN
    eh = 3; em = 1;
`else
    eh = 0; em = 0;
`endif
    cbr_load(16'h0000);
    do_fetch(8'h00, 16'h0085, d, lat, am);
    do_fetch(8'h00, 16'h0086, d, lat, am);
    do_fetch(8'h00, 16'h0087, d, lat, am);
    @(negedge clk);
    n_cmp++;
    if (hit_cnt !== 16'(eh) || miss_cnt !== 16'(em)) begin
      n_fail++;
      $display("FAIL stats got h=%0d m=%0d want h=%0d m=%0d",
               hit_cnt, miss_cnt, eh, em);
    end
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({hit_cnt, miss_cnt} !== 32'h0) begin
      n_fail++;
      $display("FAIL stats_clear got %h/%h want 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid_fill;
    int m0, lat;
    logic [7:0] d;
    logic am;
    m0 = mem_log.size();
    @(posedge clk); #1;
    bus.fetch_pbr = 8'h04; bus.fetch_pc = 16'h00A0; bus.fetch_req = 1'b1;
    wait_mem(m0 + 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.fetch_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fill_req got %b want 0", bus.mem_req);
    end
    bus.fetch_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m0 = mem_log.size();
    do_fetch(8'h00, 16'h0085, d, lat, am);
    n_cmp++;
    if (mem_log.size() - m0 !== 16) begin
      n_fail++;
      $display("FAIL rst_valid_clr got %0d reads want 16",
               mem_log.size() - m0);
    end
  endtask

  initial begin
    cbr_in = 16'h0; cbr_we = 1'b0; flush = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_pbr = 8'h0; bus.fetch_pc = 16'h0;
    bus.host_we = 1'b0; bus.host_addr = 9'h0; bus.host_data = 8'h0;
    test_reset;
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_fill;
    test_bypass;
    test_host_hit;
    test_flush_mid_fill;
    test_host_during_fill;
    test_inv_priority;
    test_stats;
    test_reset_mid_fill;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
